// File: rtl/ervp_axi_burst_packer.sv
// Packs single-beat requests into AXI INCR bursts: contiguous beats with a matching
// ID and size are merged until a break, a full burst, a flush or an idle timeout.
`ifndef BW_AXI_ASIZE
`define BW_AXI_ASIZE 3
`endif
`ifndef BW_AXI_ALEN
`define BW_AXI_ALEN 8
`endif
`ifndef BW_AXI_ABURST
`define BW_AXI_ABURST 2
`endif

module ervp_axi_burst_packer #(
  parameter int BW_ADDR   = 32,
  parameter int BW_ID     = 4,
  parameter int MAX_BEATS = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      beat_valid,
  output logic                      beat_ready,
  input  logic [BW_ID-1:0]          beat_id,
  input  logic [BW_ADDR-1:0]        beat_addr,
  input  logic [`BW_AXI_ASIZE-1:0]  beat_size,
  output logic                      ax_valid,
  input  logic                      ax_ready,
  output logic [BW_ID-1:0]          ax_id,
  output logic [BW_ADDR-1:0]        ax_addr,
  output logic [`BW_AXI_ALEN-1:0]   ax_len,
  output logic [`BW_AXI_ASIZE-1:0]  ax_size,
  output logic [`BW_AXI_ABURST-1:0] ax_burst,
  output logic                      busy
);

  localparam int CNT_W  = $clog2(MAX_BEATS + 1);
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_BEATS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, ISSUE} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           count, count_nxt;
  logic [IDLE_W-1:0]          idle_cnt, idle_cnt_nxt;
  logic [BW_ID-1:0]           start_id;
  logic [BW_ADDR-1:0]         start_addr;
  logic [`BW_AXI_ASIZE-1:0]   start_size;
  logic [BW_ADDR-1:0]         base_addr, next_addr;
  logic                       merge, load_start, ready_raw, issue;

  // The address the next beat must carry to extend the burst, kept inside one 4KB page.
  always_comb begin
    base_addr = start_addr & ~((BW_ADDR'(1) << start_size) - BW_ADDR'(1));
    next_addr = base_addr + (BW_ADDR'(count) << start_size);
    merge     = beat_valid && (beat_id == start_id) && (beat_size == start_size) &&
                (beat_addr == next_addr) && (count < MAX_CNT) &&
                (next_addr[BW_ADDR-1:12] == start_addr[BW_ADDR-1:12]);
  end

  // NOTE: every output of this block is given a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    idle_cnt_nxt = idle_cnt;
    load_start   = 1'b0;
    ready_raw    = 1'b0;
    unique case (state)
      IDLE: begin
        ready_raw = 1'b1;
        if (beat_valid) begin
          load_start   = 1'b1;
          count_nxt    = CNT_W'(1);
          idle_cnt_nxt = '0;
          state_nxt    = ACCUM;
        end
      end
      ACCUM: begin
        ready_raw = merge;
        if (merge) begin
          count_nxt    = count + CNT_W'(1);
          idle_cnt_nxt = '0;
          if ((count_nxt == MAX_CNT) || flush) state_nxt = ISSUE;
        end else if (beat_valid || (count == MAX_CNT) || flush || (idle_cnt == IDLE_LAST)) begin
          state_nxt = ISSUE;
        end else begin
          idle_cnt_nxt = idle_cnt + IDLE_W'(1);
        end
      end
      ISSUE: begin
        if (ax_ready) begin
          state_nxt    = IDLE;
          count_nxt    = '0;
          idle_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // NOTE: the burst-start registers carry no reset; they are only observed after a load, and outputs are masked outside ISSUE.
  always_ff @(posedge clk) begin
    if (load_start) begin
      start_id   <= beat_id;
      start_addr <= beat_addr;
      start_size <= beat_size;
    end
  end

  always_comb begin
    issue      = (state == ISSUE) && !rst;
    beat_ready = ready_raw && !rst;
    busy       = (state != IDLE) && !rst;
    ax_valid   = issue;
    ax_id      = issue ? start_id : '0;
    ax_addr    = issue ? start_addr : '0;
    ax_len     = issue ? `BW_AXI_ALEN'(count - CNT_W'(1)) : '0;
    ax_size    = issue ? start_size : '0;
    ax_burst   = issue ? `BW_AXI_ABURST'(1) : '0;
  end

endmodule

// File: tb/tb_ervp_axi_burst_packer.sv
// Directed self-checking bench for ervp_axi_burst_packer (default parameters:
// MAX_BEATS=16, TIMEOUT=8). Inputs change just after the falling edge; outputs are read 1ns later.
module tb_ervp_axi_burst_packer;

  logic        clk = 1'b0;
  logic        rst, flush, beat_valid, beat_ready, ax_valid, ax_ready, busy;
  logic [3:0]  beat_id, ax_id;
  logic [31:0] beat_addr, ax_addr;
  logic [2:0]  beat_size, ax_size;
  logic [7:0]  ax_len;
  logic [1:0]  ax_burst;

  int n_cmp = 0, n_bad = 0, beats_acc = 0, len_sum = 0;

  always #5 clk = ~clk;

  ervp_axi_burst_packer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_id(beat_id),
    .beat_addr(beat_addr), .beat_size(beat_size),
    .ax_valid(ax_valid), .ax_ready(ax_ready), .ax_id(ax_id), .ax_addr(ax_addr),
    .ax_len(ax_len), .ax_size(ax_size), .ax_burst(ax_burst), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge (one full clock later).
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size);
    beat_valid = 1'b1;
    beat_id    = id;
    beat_addr  = addr;
    beat_size  = size;
  endtask

  task automatic send_beat(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input logic [2:0] size);
    int n;
    drive_beat(id, addr, size);
    #1;
    n = 0;
    while (beat_ready !== 1'b1 && n < 40) begin
      cyc();
      #1;
      n++;
    end
    check({tag, "_ready"}, beat_ready, 1);
    if (beat_ready === 1'b1) beats_acc++;
    cyc();
    beat_valid = 1'b0;
  endtask

  task automatic wait_issue(input string tag, input int exp_wait);
    int n;
    #1;
    n = 0;
    while (ax_valid !== 1'b1 && n < 64) begin
      cyc();
      #1;
      n++;
    end
    check({tag, "_axv"}, ax_valid, 1);
    check({tag, "_wait"}, n, exp_wait);
  endtask

  task automatic handshake(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [3:0] id);
    #1;
    check({tag, "_valid"}, ax_valid, 1);
    check({tag, "_addr"}, ax_addr, addr);
    check({tag, "_len"}, ax_len, len);
    check({tag, "_size"}, ax_size, size);
    check({tag, "_burst"}, ax_burst, 2'b01);
    check({tag, "_id"}, ax_id, id);
    check({tag, "_bready"}, beat_ready, 0);
    check({tag, "_busy"}, busy, 1);
    len_sum += int'(ax_len) + 1;
    ax_ready = 1'b1;
    cyc();
    ax_ready = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; ax_ready = 1'b0;
    beat_valid = 1'b0; beat_id = '0; beat_addr = '0; beat_size = '0;
    cyc();
    cyc();
    #1;
    check("rst_bready", beat_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_axv", ax_valid, 0);
    check("rst_addr", ax_addr, 0);
    rst = 1'b0;
    #1;
    check("idle_bready", beat_ready, 1);
    check("idle_busy", busy, 0);
    cyc();

    // Four contiguous beats, then the idle timeout forces the issue.
    for (int i = 0; i < 4; i++) send_beat("s1", 4'd1, 32'h100 + 32'(4 * i), 3'd2);
    wait_issue("s1", 8);
    handshake("s1", 32'h100, 8'd3, 3'd2, 4'd1);
    #1;
    check("s1_axv_after", ax_valid, 0);
    check("s1_busy_after", busy, 0);

    // Twenty contiguous beats: a full 16-beat burst issued the next cycle, then a 4-beat tail.
    for (int i = 0; i < 16; i++) send_beat("s2a", 4'd3, 32'(4 * i), 3'd2);
    wait_issue("s2a", 0);
    handshake("s2a", 32'h0, 8'd15, 3'd2, 4'd3);
    for (int i = 16; i < 20; i++) send_beat("s2b", 4'd3, 32'(4 * i), 3'd2);
    wait_issue("s2b", 8);
    handshake("s2b", 32'h40, 8'd3, 3'd2, 4'd3);

    // 4KB boundary: 0x1000 may not extend the burst started at 0xFF8.
    send_beat("s3", 4'd0, 32'hFF8, 3'd2);
    send_beat("s3", 4'd0, 32'hFFC, 3'd2);
    drive_beat(4'd0, 32'h1000, 3'd2);
    #1;
    check("s3_split_bready", beat_ready, 0);
    check("s3_split_axv", ax_valid, 0);
    cyc();
    handshake("s3a", 32'hFF8, 8'd1, 3'd2, 4'd0);
    #1;
    check("s3_retry_bready", beat_ready, 1);
    if (beat_ready === 1'b1) beats_acc++;
    cyc();
    beat_valid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    handshake("s3b", 32'h1000, 8'd0, 3'd2, 4'd0);

    // ID change breaks the burst; the rejected beat is taken in IDLE.
    send_beat("s4", 4'd1, 32'h200, 3'd2);
    drive_beat(4'd2, 32'h204, 3'd2);
    #1;
    check("s4_id_bready", beat_ready, 0);
    cyc();
    handshake("s4a", 32'h200, 8'd0, 3'd2, 4'd1);
    #1;
    check("s4_retry_bready", beat_ready, 1);
    if (beat_ready === 1'b1) beats_acc++;
    cyc();
    beat_valid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    handshake("s4b", 32'h204, 8'd0, 3'd2, 4'd2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    check("s4_flush_idle_busy", busy, 0);
    cyc();

    // ax_ready withheld for 5 cycles while a mergeable beat waits.
    send_beat("s5", 4'd5, 32'h300, 3'd3);
    send_beat("s5", 4'd5, 32'h308, 3'd3);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive_beat(4'd5, 32'h310, 3'd3);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("s5_stall_axv", ax_valid, 1);
      check("s5_stall_addr", ax_addr, 32'h300);
      check("s5_stall_len", ax_len, 1);
      check("s5_stall_bready", beat_ready, 0);
      cyc();
    end
    handshake("s5a", 32'h300, 8'd1, 3'd3, 4'd5);
    #1;
    check("s5_retry_bready", beat_ready, 1);
    if (beat_ready === 1'b1) beats_acc++;
    cyc();
    beat_valid = 1'b0;
    #1;
    check("s5_axv_after", ax_valid, 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    handshake("s5b", 32'h310, 8'd0, 3'd3, 4'd5);

    // Reset mid-accumulate discards the partial burst.
    for (int i = 0; i < 3; i++) send_beat("s6", 4'd0, 32'h400 + 32'(4 * i), 3'd2);
    #1;
    check("s6_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("s6_rst_busy", busy, 0);
    check("s6_rst_bready", beat_ready, 0);
    check("s6_rst_axv", ax_valid, 0);
    cyc();
    rst = 1'b0;
    beats_acc -= 3;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (ax_valid !== 1'b0) seen = 1;
      cyc();
    end
    check("s6_no_issue", seen, 0);
    check("s6_busy_post", busy, 0);
    send_beat("s6n", 4'd0, 32'h500, 3'd2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    handshake("s6n", 32'h500, 8'd0, 3'd2, 4'd0);

    check("beat_total", beats_acc, 33);
    check("beat_conservation", len_sum, beats_acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
